// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM state encoding
// and default sizing parameters.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        LONG = 1'b1
    } state_e;

    localparam int LONG_LAT_DEF = 4;
    localparam int PERF_W_DEF   = 32;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the optional stall/flush performance counters
// (instantiated only when STALL_PERF_EN is defined).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush arbiter for a 5-stage MIPS pipeline: load-use stall, EX branch flush
// and multi-cycle EX hold. Optional perf counters under macro STALL_PERF_EN.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LONG_LAT = LONG_LAT_DEF,
    parameter int CNT_W    = 4,
    parameter int PERF_W   = PERF_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              StallReq,
    input  logic              BranchTaken_EX,
    input  logic              LongOpStart_EX,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              IDEXBubble,
    output logic              FlushIF,
    output logic              FlushID,
    output logic              EXHold,
    output logic              Busy,
    output logic [PERF_W-1:0] StallCycles,
    output logic [PERF_W-1:0] FlushCount
);

    localparam logic [CNT_W-1:0] LONG_LOAD = CNT_W'(LONG_LAT - 2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXBubble = 1'b0;
        FlushIF    = 1'b0;
        FlushID    = 1'b0;
        EXHold     = 1'b0;
        Busy       = 1'b0;

        if (!Rst) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (BranchTaken_EX) begin
                        FlushIF = 1'b1;
                        FlushID = 1'b1;
                    end
                    if (LongOpStart_EX) begin
                        EXHold  = 1'b1;
                        state_d = LONG;
                        cnt_d   = LONG_LOAD;
                        if (!BranchTaken_EX) begin
                            PCWrite   = 1'b0;
                            IFIDWrite = 1'b0;
                        end
                    end else if (StallReq && !BranchTaken_EX) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                    end
                end
                LONG: begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    EXHold    = 1'b1;
                    Busy      = 1'b1;
                    // Leave after cnt cycles (minimum one) so the whole hold,
                    // including the entry cycle in RUN, spans LONG_LAT-1 cycles.
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_EN
    logic stall_inc, flush_inc;

    assign stall_inc = Rst & ~PCWrite;
    assign flush_inc = FlushIF;

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (Clk),
        .rst_n (Rst),
        .inc   (stall_inc),
        .count (StallCycles)
    );

    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clk   (Clk),
        .rst_n (Rst),
        .inc   (flush_inc),
        .count (FlushCount)
    );
`else
    assign StallCycles = '0;
    assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed and random steps checked against a
// behavioural model of the stall/flush rules.
module tb_pipeline_stall_ctrl;

    localparam int LONG_LAT = 4;
    localparam int CNT_W    = 4;
    localparam int PERF_W   = 32;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              StallReq = 1'b0;
    logic              BranchTaken_EX = 1'b0;
    logic              LongOpStart_EX = 1'b0;
    logic              PCWrite, IFIDWrite, IDEXBubble, FlushIF, FlushID, EXHold, Busy;
    logic [PERF_W-1:0] StallCycles, FlushCount;

    int checks = 0;
    int errors = 0;

    // Model state: how many more cycles the long hold keeps the pipe frozen.
    int     m_long_left = 0;
    longint m_stall = 0;
    longint m_flush = 0;
    longint perf_max = (longint'(1) << PERF_W) - 1;

    always #5 Clk = ~Clk;

    pipeline_stall_ctrl #(
        .LONG_LAT (LONG_LAT),
        .CNT_W    (CNT_W),
        .PERF_W   (PERF_W)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .StallReq       (StallReq),
        .BranchTaken_EX (BranchTaken_EX),
        .LongOpStart_EX (LongOpStart_EX),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IDEXBubble     (IDEXBubble),
        .FlushIF        (FlushIF),
        .FlushID        (FlushID),
        .EXHold         (EXHold),
        .Busy           (Busy),
        .StallCycles    (StallCycles),
        .FlushCount     (FlushCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_perf(input string tag);
`ifdef STALL_PERF_EN
        chk({tag, "_stallcyc"}, StallCycles, 32'(m_stall));
        chk({tag, "_flushcnt"}, FlushCount, 32'(m_flush));
`else
        chk({tag, "_stallcyc"}, StallCycles, 32'd0);
        chk({tag, "_flushcnt"}, FlushCount, 32'd0);
`endif
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pcw"},    {31'd0, PCWrite},    32'd0);
        chk({tag, "_ifidw"},  {31'd0, IFIDWrite},  32'd0);
        chk({tag, "_bubble"}, {31'd0, IDEXBubble}, 32'd1);
        chk({tag, "_flif"},   {31'd0, FlushIF},    32'd0);
        chk({tag, "_flid"},   {31'd0, FlushID},    32'd0);
        chk({tag, "_exhold"}, {31'd0, EXHold},     32'd0);
        chk({tag, "_busy"},   {31'd0, Busy},       32'd0);
        chk_perf(tag);
    endtask

    // One clock cycle: drive inputs, check the Mealy outputs, advance the model.
    task automatic step(input string tag, input logic st, input logic br, input logic lo);
        logic e_pcw, e_ifidw, e_bub, e_fif, e_fid, e_hold, e_busy;
        @(negedge Clk);
        StallReq       = st;
        BranchTaken_EX = br;
        LongOpStart_EX = lo;
        #1;
        e_pcw = 1; e_ifidw = 1; e_bub = 0; e_fif = 0; e_fid = 0; e_hold = 0; e_busy = 0;
        if (m_long_left > 0) begin
            e_pcw = 0; e_ifidw = 0; e_hold = 1; e_busy = 1;
        end else if (br) begin
            e_fif = 1; e_fid = 1; e_hold = lo;
        end else if (lo) begin
            e_pcw = 0; e_ifidw = 0; e_hold = 1;
        end else if (st) begin
            e_pcw = 0; e_ifidw = 0; e_bub = 1;
        end
        chk({tag, "_pcw"},    {31'd0, PCWrite},    {31'd0, e_pcw});
        chk({tag, "_ifidw"},  {31'd0, IFIDWrite},  {31'd0, e_ifidw});
        chk({tag, "_bubble"}, {31'd0, IDEXBubble}, {31'd0, e_bub});
        chk({tag, "_flif"},   {31'd0, FlushIF},    {31'd0, e_fif});
        chk({tag, "_flid"},   {31'd0, FlushID},    {31'd0, e_fid});
        chk({tag, "_exhold"}, {31'd0, EXHold},     {31'd0, e_hold});
        chk({tag, "_busy"},   {31'd0, Busy},       {31'd0, e_busy});
        chk_perf(tag);
        if (!e_pcw && m_stall < perf_max) m_stall++;
        if (e_fif && m_flush < perf_max) m_flush++;
        if (m_long_left > 0) m_long_left--;
        else if (lo) m_long_left = (LONG_LAT - 2 < 1) ? 1 : LONG_LAT - 2;
    endtask

    task automatic model_reset();
        m_long_left = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    initial begin
        #3;
        check_reset("rst_hold0");
        #5;
        check_reset("rst_hold1");
        #4 Rst = 1'b1;

        step("idle0", 0, 0, 0);
        step("idle1", 0, 0, 0);
        step("stall0", 1, 0, 0);
        step("stall1", 1, 0, 0);
        step("after_stall", 0, 0, 0);
        step("br_stall", 1, 1, 0);
        step("after_br", 0, 0, 0);
        step("br_only", 0, 1, 0);
        step("long_start", 0, 0, 1);
        step("long_c1_st", 1, 0, 0);
        step("long_c2", 0, 0, 0);
        step("long_done", 0, 0, 0);
        step("br_long", 0, 1, 1);
        step("brl_c1", 0, 1, 0);
        step("brl_c2", 1, 0, 1);
        step("brl_done", 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom % 3) == 0, ($urandom % 5) == 0, ($urandom % 6) == 0);
        end

        step("pre_rst", 0, 0, 0);
        step("rst_long_start", 0, 0, 1);
        step("rst_long_c1", 0, 0, 0);
        @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        check_reset("rst_async");
        model_reset();
        @(posedge Clk);
        #1;
        check_reset("rst_edge");
        @(negedge Clk);
        Rst = 1'b1;
        step("post_rst0", 0, 0, 0);
        step("post_rst1", 0, 0, 0);
        step("post_rst_stall", 1, 0, 0);
        step("post_rst2", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
